// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register: sequences fetch addresses,
// tags returning words with their PC, buffers them across decode stalls and flushes on redirect.
module inst_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 10,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     hold,
  output logic [PC_W-1:0]          imem_addr,
  output logic                     imem_rden,
  input  logic [INST_W-1:0]        imem_q,
  output logic [INST_W-1:0]        instruction,
  output logic [PC_W-1:0]          PC,
  output logic [PC_W-1:0]          PCPlus1,
  output logic                     inst_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   r_fetch_pc;
  logic              r_inflight;
  logic [PC_W-1:0]   r_inflight_pc;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [INST_W-1:0] r_mem_inst [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic [CNT_W:0]    w_credit;

  assign inst_valid = (r_count != '0);
  assign count      = r_count;
  assign w_pop      = inst_valid & ~hold & ~redirect;
  // A word returning in a redirect cycle belongs to the abandoned path.
  assign w_push     = r_inflight & ~redirect;

  // Slots already committed (stored + in flight) after this cycle's pop.
  assign w_credit   = {1'b0, r_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);

  assign imem_addr  = redirect ? redirect_pc : r_fetch_pc;
  assign imem_rden  = ~rst & (redirect | (w_credit < (CNT_W+1)'(DEPTH)));

  assign instruction = inst_valid ? r_mem_inst[r_rd_ptr] : '0;
  assign PC          = inst_valid ? r_mem_pc[r_rd_ptr]   : '0;
  assign PCPlus1     = inst_valid ? r_mem_pc[r_rd_ptr] + PC_W'(1) : '0;

  // Control state: fetch sequencing, in-flight tracking, queue pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      if (imem_rden) begin
        r_fetch_pc    <= imem_addr + PC_W'(1);
        r_inflight    <= 1'b1;
        r_inflight_pc <= imem_addr;
      end else begin
        r_inflight    <= 1'b0;
      end

      if (redirect) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // Queue storage: written only on push, validity tracked by the control state
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
      r_mem_inst[r_wr_ptr] <= imem_q;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a 1-cycle synchronous instruction memory model.
module tb_inst_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        hold = 1'b0;
  logic [9:0]  imem_addr;
  logic        imem_rden;
  logic [31:0] imem_q = '0;
  logic [31:0] instruction;
  logic [9:0]  PC;
  logic [9:0]  PCPlus1;
  logic        inst_valid;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  inst_prefetch_queue #(.DEPTH(4), .PC_W(10), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .hold(hold),
    .imem_addr(imem_addr), .imem_rden(imem_rden), .imem_q(imem_q),
    .instruction(instruction), .PC(PC), .PCPlus1(PCPlus1),
    .inst_valid(inst_valid), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [9:0] a);
    return {12'hA5C, 10'h000, a};
  endfunction

  always @(posedge clk) if (imem_rden) imem_q <= memword(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs after the edge, let combinational outputs settle.
  task automatic nxt(input logic h, input logic r, input logic [9:0] rp, input logic rs);
    @(posedge clk);
    #1;
    hold = h; redirect = r; redirect_pc = rp; rst = rs;
    #2;
  endtask

  task automatic head(input string tag, input logic [9:0] pc);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, 32'(PC), 32'(pc));
    chk({tag, "_inst"}, instruction, memword(pc));
  endtask

  initial begin
    // Reset
    nxt(0, 0, 0, 1);
    chk("rst_rden", 32'(imem_rden), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", instruction, 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_pcp1", 32'(PCPlus1), 0);

    // Streaming after release (C0..C4)
    nxt(0, 0, 0, 0);
    chk("c0_valid", 32'(inst_valid), 0);
    chk("c0_rden", 32'(imem_rden), 1);
    chk("c0_addr", 32'(imem_addr), 0);
    nxt(0, 0, 0, 0);
    chk("c1_valid", 32'(inst_valid), 0);
    chk("c1_addr", 32'(imem_addr), 1);
    nxt(0, 0, 0, 0);
    head("c2", 10'd0);
    chk("c2_pcp1", 32'(PCPlus1), 1);
    chk("c2_count", 32'(count), 1);
    nxt(0, 0, 0, 0);
    head("c3", 10'd1);
    chk("c3_count", 32'(count), 1);

    // Hold for 8 cycles with PC=2 at head (C4..C11)
    nxt(1, 0, 0, 0);
    head("c4", 10'd2);
    nxt(1, 0, 0, 0);
    nxt(1, 0, 0, 0);
    chk("c6_rden", 32'(imem_rden), 0);
    nxt(1, 0, 0, 0);
    chk("c7_count", 32'(count), 4);
    chk("c7_rden", 32'(imem_rden), 0);
    chk("c7_addr", 32'(imem_addr), 6);
    for (int i = 8; i < 12; i++) nxt(1, 0, 0, 0);
    head("c11", 10'd2);
    chk("c11_count", 32'(count), 4);
    chk("c11_rden", 32'(imem_rden), 0);

    // Release: 2..7 on consecutive cycles (C12..C17)
    nxt(0, 0, 0, 0);
    head("c12", 10'd2);
    chk("c12_rden", 32'(imem_rden), 1);
    for (int i = 3; i <= 7; i++) begin
      nxt(0, 0, 0, 0);
      head("drain", 10'(i));
    end
    chk("c17_count", 32'(count), 3);

    // Redirect with 3 queued plus one in flight (C18)
    nxt(0, 1, 10'h120, 0);
    chk("c18_count", 32'(count), 3);
    chk("c18_rden", 32'(imem_rden), 1);
    chk("c18_addr", 32'(imem_addr), 32'h120);
    nxt(0, 0, 0, 0);
    chk("c19_valid", 32'(inst_valid), 0);
    chk("c19_count", 32'(count), 0);
    chk("c19_inst", instruction, 0);
    nxt(0, 0, 0, 0);
    head("c20", 10'h120);
    chk("c20_pcp1", 32'(PCPlus1), 32'h121);
    nxt(0, 0, 0, 0);
    head("c21", 10'h121);
    nxt(0, 0, 0, 0);
    head("c22", 10'h122);

    // Redirect together with hold (C23..C31)
    nxt(1, 0, 0, 0);
    head("c23", 10'h123);
    nxt(1, 0, 0, 0);
    nxt(1, 1, 10'h200, 0);
    head("c25", 10'h123);
    chk("c25_count", 32'(count), 3);
    chk("c25_addr", 32'(imem_addr), 32'h200);
    chk("c25_rden", 32'(imem_rden), 1);
    nxt(1, 0, 0, 0);
    chk("c26_valid", 32'(inst_valid), 0);
    chk("c26_count", 32'(count), 0);
    nxt(1, 0, 0, 0);
    head("c27", 10'h200);
    chk("c27_count", 32'(count), 1);
    nxt(1, 0, 0, 0);
    head("c28", 10'h200);
    chk("c28_count", 32'(count), 2);
    nxt(0, 0, 0, 0);
    head("c29", 10'h200);
    chk("c29_count", 32'(count), 3);
    nxt(0, 0, 0, 0);
    head("c30", 10'h201);
    nxt(0, 0, 0, 0);
    head("c31", 10'h202);

    // PC wrap (C32..C36)
    nxt(0, 1, 10'h3FE, 0);
    nxt(0, 0, 0, 0);
    chk("c33_valid", 32'(inst_valid), 0);
    nxt(0, 0, 0, 0);
    head("c34", 10'h3FE);
    chk("c34_pcp1", 32'(PCPlus1), 32'h3FF);
    nxt(0, 0, 0, 0);
    head("c35", 10'h3FF);
    chk("c35_pcp1", 32'(PCPlus1), 32'h000);
    nxt(0, 0, 0, 0);
    head("c36", 10'h000);
    chk("c36_pcp1", 32'(PCPlus1), 32'h001);

    // Reset mid-operation with count=3 and a read in flight (C37..C43)
    nxt(1, 0, 0, 0);
    nxt(1, 0, 0, 0);
    nxt(1, 0, 0, 1);
    chk("c39_count", 32'(count), 3);
    chk("c39_rden", 32'(imem_rden), 0);
    nxt(0, 0, 0, 0);
    chk("c40_count", 32'(count), 0);
    chk("c40_valid", 32'(inst_valid), 0);
    chk("c40_inst", instruction, 0);
    chk("c40_pc", 32'(PC), 0);
    chk("c40_pcp1", 32'(PCPlus1), 0);
    chk("c40_addr", 32'(imem_addr), 0);
    chk("c40_rden", 32'(imem_rden), 1);
    nxt(0, 0, 0, 0);
    chk("c41_valid", 32'(inst_valid), 0);
    chk("c41_count", 32'(count), 0);
    nxt(0, 0, 0, 0);
    head("c42", 10'd0);
    nxt(0, 0, 0, 0);
    head("c43", 10'd1);
    chk("c43_count", 32'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction prefetch buffer directly upstream of the IF/ID register; it takes over the sequencing role of the fetch stage.
- Drives a synchronous-read instruction memory with 1-cycle read latency and tags each returned word with its PC.
- Queues instructions so decode stalls (hold) never drop a fetched word.
- Redirects (taken branch, jump, jr) flush the queue and restart fetching at the target.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2.
PC_W, 10, PC / instruction-memory address width.
INST_W, 32, instruction width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
redirect  input  1  taken branch, jump or jr resolved in decode.
redirect_pc  input  PC_W  target address, valid when redirect=1.
hold  input  1  consumer stall; head entry is not popped.
imem_addr  output  PC_W  instruction-memory read address (combinational).
imem_rden  output  1  read issue strobe (combinational).
imem_q  input  INST_W  read data; valid the cycle after an issue.
instruction  output  INST_W  head instruction; 0 (NOP) when empty.
PC  output  PC_W  head PC; 0 when empty.
PCPlus1  output  PC_W  head PC+1, mod 2^PC_W; 0 when empty.
inst_valid  output  1  queue non-empty.
count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- State:
  - fetch_pc (PC_W)
  - inflight flag + inflight_pc tag
  - circular storage of DEPTH {pc, inst} entries with rd_ptr, wr_ptr, count
- Reset (rst=1 at an edge):
  - fetch_pc=0, count=0, pointers=0, inflight=0.
  - Outputs: inst_valid=0, instruction=0, PC=0, PCPlus1=0, count=0.
  - imem_rden=0 while rst is high.
  - Reset mid-operation discards all entries and any in-flight read, including the imem_q returned the following cycle.
- Pop:
  - pop = inst_valid & ~hold & ~redirect.
  - Head outputs come from registered storage, with no bypass from imem_q.
- Issue address: imem_addr = redirect ? redirect_pc : fetch_pc.
- Issue strobe:
  - imem_rden = ~rst & (redirect | (count + inflight - pop < DEPTH)).
  - The second term is the credit check: it guarantees no overflow and sustains 1 instruction/cycle when the consumer pops every cycle.
- On issue: fetch_pc <= imem_addr+1 (wraps 2^PC_W-1 -> 0); inflight<=1; inflight_pc<=imem_addr.
- Return and push:
  - In the cycle after an issue, if inflight=1 and no redirect this cycle, push {inflight_pc, imem_q} at wr_ptr.
  - inflight clears unless a new issue occurs.
- Redirect cycle T:
  - Flush: count=0, rd_ptr=wr_ptr.
  - Drop the returning in-flight word.
  - Issue redirect_pc in the same cycle (imem_addr=redirect_pc, imem_rden=1).
  - Result: inst_valid=0 at T+1; the target is pushed at the end of T+1; PC=redirect_pc with inst_valid=1 at T+2.
- Simultaneous events:
  - redirect has priority over hold and pop.
  - push and pop in the same cycle leave count unchanged.
  - redirect during rst: rst wins.
- Hold:
  - Outputs stay stable while hold=1.
  - The queue fills to DEPTH, then imem_rden=0 with fetch_pc frozen.
- Ordering: queue output is strictly in issue order with no duplicates or gaps between redirects.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH and never goes negative.

Test Plan:
- Reset release, hold=0: PC sequence 0,1,2,3... with inst_valid=1 from the 2nd edge after reset release; instruction matches imem contents; count stays at 1 in steady state.
- hold=1 for 8 cycles after PC=2 is at head: count reaches 4 (PCs 2..5) and imem_rden drops to 0. On release, PCs 2,3,4,5,6,7 appear on consecutive cycles with none lost or duplicated.
- Queue full plus in-flight, then redirect=1 with redirect_pc=0x120: next cycle inst_valid=0, count=0. The cycle after, PC=0x120, PCPlus1=0x121, followed by 0x121, 0x122.
- redirect and hold asserted together: flush occurs anyway. Stale word returning in the redirect cycle is never output. Target appears 2 cycles later even if hold stays 1, and holds until hold=0.
- Wrap: redirect to 0x3FE gives PCs 0x3FE, 0x3FF, 0x000, with PCPlus1 values 0x3FF, 0x000, 0x001.
- rst pulsed while count=3 and a read is in flight: next cycle count=0 and all outputs are 0. After release, fetch restarts at PC 0 and the pre-reset imem_q is never pushed.
